// File: rtl/video_ula.sv
// Video ULA: character/pixel clock enables, screen-byte serialiser, 16-entry palette
// and registered RGB output with blanking, flash and cursor inversion.
module video_ula (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       PROC_en,
    input  logic       nCS_VIDULA,
    input  logic       RnW,
    input  logic       A0,
    input  logic [7:0] pDATABUS,
    input  logic [7:0] VRAM_DATA,
    input  logic       DISEN,
    input  logic       CURSOR,
    output logic       CRTC_en,
    output logic       RED,
    output logic       GREEN,
    output logic       BLUE
);

    logic [3:0] r_cnt;
    logic [7:0] r_ctrl;
    logic [3:0] r_palette [16];
    logic [7:0] r_shift;
    logic       r_blank;
    logic       r_cur;
    logic [2:0] r_rgb;

    logic       w_wr;
    logic       w_crtc_en;
    logic       w_pix_en;
    logic [3:0] w_logical;
    logic [3:0] w_phys;
    logic [2:0] w_colour;
    logic       w_unused_ctrl;

    assign w_wr = ~nCS_VIDULA & ~RnW & PROC_en;

    assign w_crtc_en = r_ctrl[4] ? (r_cnt[2:0] == 3'd7) : (r_cnt == 4'd15);

    always_comb begin
        w_pix_en = 1'b0;
        unique case (r_ctrl[3:2])
            2'b00:   w_pix_en = (r_cnt[2:0] == 3'd7);
            2'b01:   w_pix_en = (r_cnt[1:0] == 2'd3);
            2'b10:   w_pix_en = r_cnt[0];
            2'b11:   w_pix_en = 1'b1;
            default: w_pix_en = 1'b0;
        endcase
    end

    // Logical colour is taken from alternate bits so every mode reads the same bit positions.
    assign w_logical = {r_shift[7], r_shift[5], r_shift[3], r_shift[1]};
    assign w_phys    = r_palette[w_logical];

    always_comb begin
        w_colour = ~w_phys[2:0];
        if (w_phys[3] & r_ctrl[0]) begin
            w_colour = ~w_colour;
        end
        if (r_blank) begin
            w_colour = 3'b000;
        end
        if (r_cur) begin
            w_colour = w_colour ^ 3'b111;
        end
    end

    // Teletext select and spare bits are held for software but drive nothing.
    assign w_unused_ctrl = ^{r_ctrl[6:5], r_ctrl[1]};

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_ctrl <= 8'h00;
            for (int i = 0; i < 16; i++) begin
                r_palette[i] <= 4'h0;
            end
        end else if (w_wr) begin
            if (A0) begin
                r_palette[pDATABUS[7:4]] <= pDATABUS[3:0];
            end else begin
                r_ctrl <= pDATABUS;
            end
        end
    end

    // The colour registered at a load edge still comes from the previous byte's last pixel.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            r_shift <= 8'h00;
            r_blank <= 1'b1;
            r_cur   <= 1'b0;
            r_rgb   <= 3'b000;
        end else if (w_pix_en) begin
            r_rgb <= w_colour;
            if (w_crtc_en) begin
                r_shift <= DISEN ? VRAM_DATA : 8'h00;
                r_blank <= ~DISEN;
                r_cur   <= CURSOR & r_ctrl[7];
            end else begin
                r_shift <= {r_shift[6:0], 1'b1};
            end
        end
    end

    assign CRTC_en = w_crtc_en;
    assign RED     = r_rgb[2];
    assign GREEN   = r_rgb[1];
    assign BLUE    = r_rgb[0];

endmodule

// File: tb/tb_video_ula.sv
// Randomised bench for video_ula: a pixel-index reference model predicts RGB and
// CRTC_en every cycle, including writes, mode changes and mid-line resets.
module tb_video_ula;

    logic       CLK;
    logic       nRESET;
    logic       PROC_en;
    logic       nCS_VIDULA;
    logic       RnW;
    logic       A0;
    logic [7:0] pDATABUS;
    logic [7:0] VRAM_DATA;
    logic       DISEN;
    logic       CURSOR;
    logic       CRTC_en;
    logic       RED;
    logic       GREEN;
    logic       BLUE;

    int n_vectors = 0;
    int n_errors  = 0;

    // Reference state: cycles since reset, registers, and the current byte plus
    // how many pixel steps have elapsed since it was loaded.
    int         m_cnt;
    logic [7:0] m_ctrl;
    logic [3:0] m_pal [16];
    logic [7:0] m_byte;
    int         m_k;
    logic       m_blank;
    logic       m_cur;
    logic [2:0] m_rgb;

    video_ula u_dut (
        .CLK        (CLK),
        .nRESET     (nRESET),
        .PROC_en    (PROC_en),
        .nCS_VIDULA (nCS_VIDULA),
        .RnW        (RnW),
        .A0         (A0),
        .pDATABUS   (pDATABUS),
        .VRAM_DATA  (VRAM_DATA),
        .DISEN      (DISEN),
        .CURSOR     (CURSOR),
        .CRTC_en    (CRTC_en),
        .RED        (RED),
        .GREEN      (GREEN),
        .BLUE       (BLUE)
    );

    initial CLK = 1'b0;
    always #31 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic exp_crtc();
        if (m_ctrl[4]) return (m_cnt % 8) == 7;
        return m_cnt == 15;
    endfunction

    function automatic logic exp_pix();
        case (m_ctrl[3:2])
            2'd3:    return 1'b1;
            2'd2:    return (m_cnt % 2) == 1;
            2'd1:    return (m_cnt % 4) == 3;
            default: return (m_cnt % 8) == 7;
        endcase
    endfunction

    // Pixel k of a byte sees the byte moved left k places with ones filling in.
    function automatic logic [2:0] pixel_colour();
        logic [15:0] wide;
        logic [7:0]  s;
        logic [3:0]  l;
        logic [3:0]  p;
        logic [2:0]  c;
        if (m_k >= 8) begin
            s = 8'hFF;
        end else begin
            wide = {m_byte, 8'hFF} << m_k;
            s = wide[15:8];
        end
        l = {s[7], s[5], s[3], s[1]};
        p = m_pal[l];
        c = ~p[2:0];
        if (p[3] && m_ctrl[0]) c = ~c;
        if (m_blank) c = 3'b000;
        if (m_cur) c = c ^ 3'b111;
        return c;
    endfunction

    task automatic model_reset();
        m_cnt   = 0;
        m_ctrl  = 8'h00;
        for (int i = 0; i < 16; i++) m_pal[i] = 4'h0;
        m_byte  = 8'h00;
        m_k     = 0;
        m_blank = 1'b1;
        m_cur   = 1'b0;
        m_rgb   = 3'b000;
    endtask

    // Advance the model across the coming rising edge using the inputs now driven.
    task automatic model_edge();
        logic crtc;
        logic pix;
        crtc = exp_crtc();
        pix  = exp_pix();
        if (pix) begin
            m_rgb = pixel_colour();
            if (crtc) begin
                m_byte  = DISEN ? VRAM_DATA : 8'h00;
                m_k     = 0;
                m_blank = ~DISEN;
                m_cur   = CURSOR & m_ctrl[7];
            end else begin
                m_k++;
            end
        end
        if (!nCS_VIDULA && !RnW && PROC_en) begin
            if (A0) m_pal[pDATABUS[7:4]] = pDATABUS[3:0];
            else m_ctrl = pDATABUS;
        end
        m_cnt = (m_cnt + 1) % 16;
    endtask

    task automatic step(input logic ncs, input logic rnw, input logic pen, input logic a0,
                        input logic [7:0] d, input logic [7:0] vram, input logic disen,
                        input logic cursor);
        @(negedge CLK);
        check("rgb", {5'd0, RED, GREEN, BLUE}, {5'd0, m_rgb});
        check("crtc_en", {7'd0, CRTC_en}, {7'd0, exp_crtc()});
        nCS_VIDULA = ncs;
        RnW        = rnw;
        PROC_en    = pen;
        A0         = a0;
        pDATABUS   = d;
        VRAM_DATA  = vram;
        DISEN      = disen;
        CURSOR     = cursor;
        model_edge();
    endtask

    task automatic write_reg(input logic a0, input logic [7:0] d,
                             input logic [7:0] vram, input logic disen, input logic cursor);
        step(1'b0, 1'b0, 1'b1, a0, d, vram, disen, cursor);
    endtask

    task automatic idle(input int n, input logic [7:0] vram, input logic disen,
                        input logic cursor);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, vram, disen, cursor);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        nRESET = 1'b0;
        #1;
        model_reset();
        check("rst_rgb", {5'd0, RED, GREEN, BLUE}, 8'd0);
        check("rst_crtc_en", {7'd0, CRTC_en}, 8'd0);
        @(negedge CLK);
        check("rst_hold_rgb", {5'd0, RED, GREEN, BLUE}, 8'd0);
        nCS_VIDULA = 1'b1;
        RnW        = 1'b1;
        PROC_en    = 1'b0;
        nRESET     = 1'b1;
        model_edge();
    endtask

    initial begin
        nRESET     = 1'b0;
        PROC_en    = 1'b0;
        nCS_VIDULA = 1'b1;
        RnW        = 1'b1;
        A0         = 1'b0;
        pDATABUS   = 8'h00;
        VRAM_DATA  = 8'h00;
        DISEN      = 1'b0;
        CURSOR     = 1'b0;
        model_reset();
        do_reset();

        // Free-running after reset with no register writes.
        idle(40, 8'hFF, 1'b1, 1'b1);

        // Fast character clock, 16 MHz pixels, cursor enabled.
        write_reg(1'b0, 8'h9C, 8'hA5, 1'b1, 1'b0);
        write_reg(1'b1, 8'h07, 8'hA5, 1'b1, 1'b0);
        write_reg(1'b1, 8'h80, 8'hA5, 1'b1, 1'b0);
        write_reg(1'b1, 8'hC3, 8'hA5, 1'b1, 1'b0);
        idle(24, 8'hA5, 1'b1, 1'b0);
        idle(16, 8'hA5, 1'b1, 1'b1);

        // 4 MHz pixels, 2 bpp.
        write_reg(1'b0, 8'hC4, 8'hF0, 1'b1, 1'b0);
        write_reg(1'b1, 8'hA1, 8'hF0, 1'b1, 1'b0);
        idle(32, 8'hF0, 1'b1, 1'b0);

        // Flash phase toggle on a flashing palette entry.
        write_reg(1'b1, 8'h09, 8'h00, 1'b1, 1'b0);
        write_reg(1'b0, 8'h00, 8'h00, 1'b1, 1'b0);
        idle(20, 8'h00, 1'b1, 1'b0);
        write_reg(1'b0, 8'h01, 8'h00, 1'b1, 1'b0);
        idle(20, 8'h00, 1'b1, 1'b0);

        // Blanked load with and without cursor.
        write_reg(1'b0, 8'h80, 8'hFF, 1'b0, 1'b1);
        idle(34, 8'hFF, 1'b0, 1'b1);
        write_reg(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1);
        idle(34, 8'hFF, 1'b0, 1'b1);

        // Reset mid-character in 16 MHz mode.
        write_reg(1'b0, 8'h1C, 8'h5A, 1'b1, 1'b0);
        idle(21, 8'h5A, 1'b1, 1'b0);
        do_reset();
        idle(34, 8'h5A, 1'b1, 1'b0);

        // Randomised traffic: writes, non-qualified bus cycles, data and occasional resets.
        for (int i = 0; i < 4000; i++) begin
            int unsigned r;
            r = $urandom_range(0, 999);
            if (r < 3) begin
                do_reset();
            end else if (r < 100) begin
                write_reg(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                          ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2));
            end else begin
                step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                     ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 2));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
        $finish;
    end

endmodule
